nec_ir_rx: RTL and testbench
============================

Name: nec_ir_rx

Overview:
- Parametrised successor of the fixed-timing IR decoder FSM.
- Measures the width of every mark/space on the IR line against NEC windows derived from CLK_HZ and TOL_PCT, and assembles the 32-bit frame internally (no external shift register).
- Delivers frames over a valid/ready handshake, flags repeat codes, and counts protocol errors.
- Sits between the IR receiver pin and the command/display logic.

Parameters:
- CLK_HZ, 50000000, system clock frequency; all timing constants are derived from it at elaboration.
- TOL_PCT, 25, accepted deviation of each measured width from nominal, in percent.
- IR_ACTIVE_HIGH, 1, 1 = a mark is ir high; 0 = a mark is ir low.
- SYNC_STAGES, 2, number of synchroniser flops on ir (minimum 2).
- RPT_WINDOW_MS, 120, maximum time from the end of the last good frame or repeat within which a repeat code is honoured.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ir  in  1  raw, asynchronous IR demodulator output
- frame_data  out  32  received frame, LSB = first bit on air; [7:0] addr, [15:8] ~addr, [23:16] cmd, [31:24] ~cmd
- frame_valid  out  1  frame_data holds an unaccepted frame
- frame_ready  in  1  consumer accepts the frame when frame_valid is high
- rpt  out  1  one-cycle pulse on a valid repeat code
- overrun  out  1  sticky; a frame was dropped while frame_valid was high
- err_count  out  8  saturating count of aborted frames
- busy  out  1  decoder is outside IDLE

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on port reset. All state updates occur on posedge clk.
- Reset values: frame_data = 0, frame_valid = 0, rpt = 0, overrun = 0, err_count = 0, busy = 0, FSM = IDLE, repeat timer expired.
- Input path:
  - ir passes through SYNC_STAGES flops, then polarity is normalised to "mark".
  - An edge is detected when the synchronised value differs from its one-cycle-delayed copy.
  - Total input latency is SYNC_STAGES + 1 cycles.
- Width counter:
  - Clears on every edge and otherwise increments.
  - Saturates at 1.5 × the 9 ms lead-mark upper bound.
  - Width is $clog2 of that saturation value.
- Windows: nominal N cycles = CLK_HZ × t; accepted range is N×(100−TOL_PCT)/100 to N×(100+TOL_PCT)/100, integer-truncated and computed at elaboration.
- Nominals: lead mark 9 ms; data space 4.5 ms; repeat space 2.25 ms; bit mark 562.5 us; zero space 562.5 us; one space 1687.5 us.
- FSM states and transitions; each measured width is evaluated at the edge that terminates it:
  - IDLE: a mark edge -> LEAD_MARK.
  - LEAD_MARK: space edge with width in the lead window -> LEAD_SPACE; otherwise -> ERROR.
  - LEAD_SPACE: mark edge with width in the data window -> BIT_MARK with bit index = 0; in the repeat window -> RPT_MARK; otherwise -> ERROR.
  - BIT_MARK: space edge with width in the bit-mark window -> BIT_SPACE; otherwise -> ERROR.
  - BIT_SPACE: on a mark edge:
    - zero window: shift in 0;
    - one window: shift in 1;
    - any other width -> ERROR;
    - after shifting, index 31 -> STOP_MARK, else index+1 -> BIT_MARK.
  - STOP_MARK: space edge with width in the bit-mark window -> DONE; otherwise -> ERROR.
  - RPT_MARK: space edge with width in the bit-mark window -> IDLE, and rpt pulses for 1 cycle if the repeat timer has not expired; otherwise -> ERROR.
  - DONE (1 cycle): load the output and restart the repeat timer -> IDLE.
  - ERROR (1 cycle): err_count += 1, saturating at 255 -> IDLE; any partial shift data is discarded.
- Timeout: in any state other than IDLE, the counter reaching saturation with no edge -> ERROR.
- Handshake:
  - frame_valid and frame_data stay stable until a cycle with frame_valid & frame_ready; frame_valid falls on the following edge.
  - DONE while frame_valid = 1 and frame_ready = 0: the new frame is dropped, overrun is set, the old data is kept.
  - DONE in the same cycle as an acceptance: the new frame loads and frame_valid stays 1, with no overrun.
  - overrun clears only on reset.
- Repeat timer:
  - Counts RPT_WINDOW_MS and saturates at "expired".
  - Restarted by DONE and by every honoured rpt.
  - A repeat code received after expiry is ignored: no rpt, no error.
- busy = (state != IDLE).
- Reset asserted mid-frame: everything returns to reset values on the next edge, and the partial frame is discarded.

Optional Feature:
- Macro: NEC_STRICT_CHECK_EN.
- Defined: in DONE, if frame_data[15:8] != ~[7:0] or [31:24] != ~[23:16], the FSM goes to ERROR instead of loading. err_count increments; frame_valid, overrun and the repeat timer are unchanged.
- Undefined: all 32 bits are delivered unchecked (extended-address NEC frames pass).

Test Plan:
- Frame addr 0x00, cmd 0x45 (word 0xBA45FF00), frame_ready = 1 -> frame_valid for exactly 1 cycle with frame_data = 0xBA45FF00, err_count = 0.
- Same frame, then a repeat code 40 ms after the stop mark, then a second repeat code 150 ms after the first -> the first repeat gives one rpt pulse; the second gives none (window expired) and err_count stays 0.
- Two frames, 0xBA45FF00 then 0xE718FF00, with frame_ready held at 0 -> frame_data stays 0xBA45FF00 and overrun = 1; with frame_ready = 1 for one cycle -> frame_valid falls.
- Lead mark of 6 ms (outside 9 ms ±25%) -> err_count = 1, no frame_valid; followed immediately by a good frame -> that frame is decoded correctly.
- ir held at mark 30 ms mid-frame (after bit 10) -> err_count increments, busy falls; reset asserted during a later frame -> all outputs return to 0.
- With NEC_STRICT_CHECK_EN, word 0xBA46FF00 -> no frame_valid and err_count += 1; without the macro, the same frame is delivered.

Source files
------------

// File: rtl/nec_ir_rx.sv
// NEC IR frame decoder: measures mark/space widths against CLK_HZ/TOL_PCT windows, assembles 32-bit frames.
// Optional build macro NEC_STRICT_CHECK_EN rejects frames whose address/command complements do not match.
module nec_ir_rx #(
  parameter int unsigned CLK_HZ        = 50_000_000,
  parameter int unsigned TOL_PCT       = 25,
  parameter bit          IR_ACTIVE_HIGH = 1'b1,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned RPT_WINDOW_MS = 120
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ir,
  output logic [31:0] frame_data,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic        rpt,
  output logic        overrun,
  output logic [7:0]  err_count,
  output logic        busy
);

  // Durations are given in 100 ns units so 562.5 us stays an integer.
  function automatic int unsigned nom_cyc(input longint unsigned t_100ns);
    return 32'((64'(CLK_HZ) * t_100ns) / 64'd10_000_000);
  endfunction

  function automatic int unsigned lo_of(input int unsigned n);
    return 32'((64'(n) * 64'(100 - TOL_PCT)) / 64'd100);
  endfunction

  function automatic int unsigned hi_of(input int unsigned n);
    return 32'((64'(n) * 64'(100 + TOL_PCT)) / 64'd100);
  endfunction

  localparam int unsigned LEAD_N  = nom_cyc(64'd90000);
  localparam int unsigned DATA_N  = nom_cyc(64'd45000);
  localparam int unsigned RPT_N   = nom_cyc(64'd22500);
  localparam int unsigned BIT_N   = nom_cyc(64'd5625);
  localparam int unsigned ONE_N   = nom_cyc(64'd16875);

  localparam int unsigned LEAD_LO = lo_of(LEAD_N);
  localparam int unsigned LEAD_HI = hi_of(LEAD_N);
  localparam int unsigned DATA_LO = lo_of(DATA_N);
  localparam int unsigned DATA_HI = hi_of(DATA_N);
  localparam int unsigned RPT_LO  = lo_of(RPT_N);
  localparam int unsigned RPT_HI  = hi_of(RPT_N);
  localparam int unsigned BIT_LO  = lo_of(BIT_N);
  localparam int unsigned BIT_HI  = hi_of(BIT_N);
  localparam int unsigned ONE_LO  = lo_of(ONE_N);
  localparam int unsigned ONE_HI  = hi_of(ONE_N);

  localparam int unsigned SAT_VAL = (LEAD_HI * 3) / 2;
  localparam int unsigned CW      = $clog2(SAT_VAL + 1);
  localparam int unsigned RPT_CYC = 32'((64'(CLK_HZ) * 64'(RPT_WINDOW_MS)) / 64'd1000);
  localparam int unsigned RW      = $clog2(RPT_CYC + 1);

  typedef enum logic [3:0] {
    IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, RPT_MARK, DONE, ERROR
  } state_t;

  function automatic logic in_win(input logic [CW-1:0] w, input int unsigned lo,
                                  input int unsigned hi);
    return (32'(w) >= lo) && (32'(w) <= hi);
  endfunction

  logic [SYNC_STAGES-1:0] sync;
  logic                   mark_d;
  logic [CW-1:0]          cnt;
  logic [RW-1:0]          rpt_cnt;
  state_t                 state, state_next;
  logic [4:0]             idx, idx_next;
  logic [31:0]            shreg, shreg_next;
  logic                   mark_c, edge_c, mark_edge_c, space_edge_c, sat_c, expired_c;
  logic                   meas_c, rpt_hit_c, load_hit_c;

  assign mark_c       = sync[SYNC_STAGES-1] ~^ IR_ACTIVE_HIGH;
  assign edge_c       = mark_c ^ mark_d;
  assign mark_edge_c  = edge_c & mark_c;
  assign space_edge_c = edge_c & ~mark_c;
  assign sat_c        = (cnt == CW'(SAT_VAL));
  assign expired_c    = (rpt_cnt == RW'(RPT_CYC));
  assign meas_c       = state inside {LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, RPT_MARK};

  // Synchroniser and width counter; the counter restarts at every level change.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync   <= {SYNC_STAGES{~IR_ACTIVE_HIGH}};
      mark_d <= 1'b0;
      cnt    <= '0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], ir};
      mark_d <= mark_c;
      if (edge_c)      cnt <= '0;
      else if (!sat_c) cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      shreg <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      shreg <= shreg_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    shreg_next = shreg;
    rpt_hit_c  = 1'b0;
    load_hit_c = 1'b0;
    unique case (state)
      IDLE: if (mark_edge_c) state_next = LEAD_MARK;
      LEAD_MARK:
        if (edge_c) state_next = (space_edge_c && in_win(cnt, LEAD_LO, LEAD_HI)) ? LEAD_SPACE : ERROR;
      LEAD_SPACE:
        if (edge_c) begin
          if (mark_edge_c && in_win(cnt, DATA_LO, DATA_HI)) begin
            state_next = BIT_MARK;
            idx_next   = '0;
            shreg_next = '0;
          end else if (mark_edge_c && in_win(cnt, RPT_LO, RPT_HI)) begin
            state_next = RPT_MARK;
          end else begin
            state_next = ERROR;
          end
        end
      BIT_MARK:
        if (edge_c) state_next = (space_edge_c && in_win(cnt, BIT_LO, BIT_HI)) ? BIT_SPACE : ERROR;
      BIT_SPACE:
        if (edge_c) begin
          if (mark_edge_c && (in_win(cnt, BIT_LO, BIT_HI) || in_win(cnt, ONE_LO, ONE_HI))) begin
            shreg_next = {in_win(cnt, ONE_LO, ONE_HI), shreg[31:1]};
            if (idx == 5'd31) begin
              state_next = STOP_MARK;
            end else begin
              idx_next   = idx + 5'd1;
              state_next = BIT_MARK;
            end
          end else begin
            state_next = ERROR;
          end
        end
      STOP_MARK:
        if (edge_c) state_next = (space_edge_c && in_win(cnt, BIT_LO, BIT_HI)) ? DONE : ERROR;
      RPT_MARK:
        if (edge_c) begin
          if (space_edge_c && in_win(cnt, BIT_LO, BIT_HI)) begin
            state_next = IDLE;
            rpt_hit_c  = ~expired_c;
          end else begin
            state_next = ERROR;
          end
        end
      DONE: begin
`ifdef NEC_STRICT_CHECK_EN
        if ((shreg[15:8] != ~shreg[7:0]) || (shreg[31:24] != ~shreg[23:16])) begin
          state_next = ERROR;
        end else begin
          load_hit_c = 1'b1;
          state_next = IDLE;
        end
`else
        load_hit_c = 1'b1;
        state_next = IDLE;
`endif
      end
      ERROR: begin
        shreg_next = '0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // A line stuck in one level for too long aborts the frame.
    if (meas_c && !edge_c && sat_c) state_next = ERROR;
  end

  // Output handshake, repeat timer and error statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_data  <= '0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
      err_count   <= '0;
      rpt         <= 1'b0;
      busy        <= 1'b0;
      rpt_cnt     <= RW'(RPT_CYC);
    end else begin
      rpt  <= rpt_hit_c;
      busy <= (state_next != IDLE);
      if (load_hit_c) begin
        if (!frame_valid || frame_ready) begin
          frame_data  <= shreg;
          frame_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
      if (load_hit_c || rpt_hit_c) rpt_cnt <= '0;
      else if (!expired_c)         rpt_cnt <= rpt_cnt + RW'(1);
      if (state == ERROR && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_nec_ir_rx.sv
// Self-checking bench for nec_ir_rx: directed NEC scenarios plus randomized frames with jittered timing.
module tb_nec_ir_rx;

  localparam int unsigned CLK_HZ = 40_000;
  localparam int unsigned TOL    = 25;

  localparam int unsigned N_LEAD = 32'((64'(CLK_HZ) * 64'd90000) / 64'd10_000_000);
  localparam int unsigned N_DATA = 32'((64'(CLK_HZ) * 64'd45000) / 64'd10_000_000);
  localparam int unsigned N_RPT  = 32'((64'(CLK_HZ) * 64'd22500) / 64'd10_000_000);
  localparam int unsigned N_BIT  = 32'((64'(CLK_HZ) * 64'd5625) / 64'd10_000_000);
  localparam int unsigned N_ONE  = 32'((64'(CLK_HZ) * 64'd16875) / 64'd10_000_000);

  logic        clk = 1'b0;
  logic        reset, ir, frame_ready;
  logic [31:0] frame_data;
  logic        frame_valid, rpt, overrun, busy;
  logic [7:0]  err_count;

  int          checks = 0;
  int          errors = 0;
  int          valid_cycles = 0;
  int          rpt_cycles = 0;
  logic [31:0] last_data = '0;

  always #5 clk = ~clk;

  nec_ir_rx #(
    .CLK_HZ(CLK_HZ), .TOL_PCT(TOL), .IR_ACTIVE_HIGH(1'b1), .SYNC_STAGES(2), .RPT_WINDOW_MS(120)
  ) dut (
    .clk(clk), .reset(reset), .ir(ir), .frame_data(frame_data), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .rpt(rpt), .overrun(overrun), .err_count(err_count), .busy(busy)
  );

  // Records delivered frames and repeat pulses.
  always @(negedge clk) begin
    if (frame_valid) begin
      valid_cycles++;
      last_data = frame_data;
    end
    if (rpt) rpt_cycles++;
  end

  function automatic int unsigned ms(input int unsigned x);
    return (CLK_HZ * x) / 1000;
  endfunction

  function automatic int unsigned jit(input int unsigned n, input bit en);
    if (!en) return n;
    return (n * (90 + $urandom_range(20, 0))) / 100;
  endfunction

  // Reference rule: a width is acceptable when within TOL percent of nominal.
  function automatic bit in_band(input int unsigned d, input int unsigned nom);
    return (d * 100 >= nom * (100 - TOL)) && (d * 100 <= nom * (100 + TOL));
  endfunction

  task automatic pulse(input logic lvl, input int unsigned cyc);
    ir = lvl;
    repeat (cyc) @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    ir = 1'b0;
    frame_ready = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    valid_cycles = 0;
    rpt_cycles = 0;
  endtask

  task automatic drive_head(input logic [31:0] w, input int nbits, input bit j, output bit ok);
    int unsigned d, nom;
    ok = 1'b1;
    d = jit(N_LEAD, j); ok = ok & in_band(d, N_LEAD); pulse(1'b1, d);
    d = jit(N_DATA, j); ok = ok & in_band(d, N_DATA); pulse(1'b0, d);
    for (int i = 0; i < nbits; i++) begin
      d = jit(N_BIT, j); ok = ok & in_band(d, N_BIT); pulse(1'b1, d);
      nom = w[i] ? N_ONE : N_BIT;
      d = jit(nom, j); ok = ok & in_band(d, nom); pulse(1'b0, d);
    end
  endtask

  task automatic send_frame(input logic [31:0] w, input bit j, input int unsigned stop_pct,
                            output bit ok);
    int unsigned d;
    drive_head(w, 32, j, ok);
    d = (jit(N_BIT, j) * stop_pct) / 100;
    ok = ok & in_band(d, N_BIT);
    pulse(1'b1, d);
    pulse(1'b0, ms(5));
  endtask

  task automatic send_repeat();
    pulse(1'b1, N_LEAD);
    pulse(1'b0, N_RPT);
    pulse(1'b1, N_BIT);
    pulse(1'b0, ms(5));
  endtask

  task automatic test_reset();
    @(negedge clk);
    ir = 1'b1;
    frame_ready = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (frame_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h exp 0", frame_data); end
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", frame_valid); end
    checks++; if (rpt !== 1'b0) begin errors++; $display("FAIL reset_rpt: got %b exp 0", rpt); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b exp 0", overrun); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err: got %0d exp 0", err_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    reset = 1'b0;
  endtask

  task automatic test_single_frame();
    bit ok;
    apply_reset();
    send_frame(32'hBA45FF00, 1'b0, 100, ok);
    checks++; if (valid_cycles != 1) begin errors++; $display("FAIL single_valid_cycles: got %0d exp 1", valid_cycles); end
    checks++; if (last_data !== 32'hBA45FF00) begin errors++; $display("FAIL single_data: got %h exp ba45ff00", last_data); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL single_err: got %0d exp 0", err_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b exp 0", busy); end
  endtask

  task automatic test_repeat();
    bit ok;
    apply_reset();
    send_frame(32'hBA45FF00, 1'b0, 100, ok);
    pulse(1'b0, ms(35));
    send_repeat();
    checks++; if (rpt_cycles != 1) begin errors++; $display("FAIL repeat_first: got %0d pulses exp 1", rpt_cycles); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL repeat_first_err: got %0d exp 0", err_count); end
    pulse(1'b0, ms(133));
    send_repeat();
    checks++; if (rpt_cycles != 1) begin errors++; $display("FAIL repeat_expired: got %0d pulses exp 1", rpt_cycles); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL repeat_expired_err: got %0d exp 0", err_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL repeat_busy: got %b exp 0", busy); end
  endtask

  task automatic test_overrun();
    bit ok;
    apply_reset();
    frame_ready = 1'b0;
    send_frame(32'hBA45FF00, 1'b1, 100, ok);
    send_frame(32'hE718FF00, 1'b1, 100, ok);
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL overrun_valid: got %b exp 1", frame_valid); end
    checks++; if (frame_data !== 32'hBA45FF00) begin errors++; $display("FAIL overrun_data: got %h exp ba45ff00", frame_data); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag: got %b exp 1", overrun); end
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL overrun_accept: got %b exp 0", frame_valid); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b exp 1", overrun); end
  endtask

  task automatic test_bad_lead();
    bit ok;
    apply_reset();
    pulse(1'b1, ms(6));
    pulse(1'b0, ms(10));
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL bad_lead_err: got %0d exp 1", err_count); end
    checks++; if (valid_cycles != 0) begin errors++; $display("FAIL bad_lead_valid: got %0d exp 0", valid_cycles); end
    send_frame(32'hE718FF00, 1'b1, 100, ok);
    checks++; if (valid_cycles != 1) begin errors++; $display("FAIL after_bad_valid: got %0d exp 1", valid_cycles); end
    checks++; if (last_data !== 32'hE718FF00) begin errors++; $display("FAIL after_bad_data: got %h exp e718ff00", last_data); end
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL after_bad_err: got %0d exp 1", err_count); end
  endtask

  task automatic test_timeout_and_reset();
    bit ok;
    apply_reset();
    drive_head(32'hBA45FF00, 11, 1'b0, ok);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL timeout_busy_mid: got %b exp 1", busy); end
    pulse(1'b1, ms(30));
    pulse(1'b0, ms(5));
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL timeout_err: got %0d exp 1", err_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy: got %b exp 0", busy); end
    checks++; if (valid_cycles != 0) begin errors++; $display("FAIL timeout_valid: got %0d exp 0", valid_cycles); end
    drive_head(32'h12345678, 5, 1'b1, ok);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midreset_busy_before: got %b exp 1", busy); end
    ir = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL midreset_err: got %0d exp 0", err_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b exp 0", busy); end
    checks++; if (frame_data !== 32'h0) begin errors++; $display("FAIL midreset_data: got %h exp 0", frame_data); end
    checks++; if (frame_valid !== 1'b0 || overrun !== 1'b0 || rpt !== 1'b0) begin
      errors++; $display("FAIL midreset_flags: got valid=%b overrun=%b rpt=%b exp 0", frame_valid, overrun, rpt);
    end
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_strict();
    bit ok;
    apply_reset();
    send_frame(32'hBA46FF00, 1'b0, 100, ok);
`ifdef NEC_STRICT_CHECK_EN
    checks++; if (valid_cycles != 0) begin errors++; $display("FAIL strict_valid: got %0d exp 0", valid_cycles); end
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL strict_err: got %0d exp 1", err_count); end
`else
    checks++; if (valid_cycles != 1) begin errors++; $display("FAIL strict_valid: got %0d exp 1", valid_cycles); end
    checks++; if (last_data !== 32'hBA46FF00) begin errors++; $display("FAIL strict_data: got %h exp ba46ff00", last_data); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL strict_err: got %0d exp 0", err_count); end
`endif
  endtask

  task automatic test_random_frames();
    bit          ok;
    logic [7:0]  addr, addr_hi, cmd;
    logic [31:0] w;
    int unsigned stop_pct;
    int          exp_valid = 0;
    int          exp_err = 0;
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      addr = 8'($urandom);
      cmd  = 8'($urandom);
      addr_hi = ($urandom_range(3, 0) == 0) ? 8'($urandom) : ~addr;
      w = {~cmd, cmd, addr_hi, addr};
      stop_pct = 100;
      if ($urandom_range(2, 0) == 0) stop_pct = ($urandom_range(1, 0) == 1) ? 50 : 160;
      send_frame(w, 1'b1, stop_pct, ok);
`ifdef NEC_STRICT_CHECK_EN
      ok = ok && (addr_hi == ~addr);
`endif
      if (ok) exp_valid++;
      else    exp_err++;
      checks++; if (valid_cycles != exp_valid) begin errors++; $display("FAIL rand_valid[%0d]: got %0d exp %0d", k, valid_cycles, exp_valid); end
      checks++; if (err_count !== 8'(exp_err)) begin errors++; $display("FAIL rand_err[%0d]: got %0d exp %0d", k, err_count, exp_err); end
      if (ok) begin
        checks++; if (last_data !== w) begin errors++; $display("FAIL rand_data[%0d]: got %h exp %h", k, last_data, w); end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    ir = 1'b0;
    frame_ready = 1'b1;
    test_reset();
    test_single_frame();
    test_repeat();
    test_overrun();
    test_bad_lead();
    test_timeout_and_reset();
    test_strict();
    test_random_frames();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
